reorder_buffer: RTL and testbench

In-order retirement queue for the out-of-order core, sitting between issue, the common data bus (CDB) and the architectural register file. It allocates a wrap-tagged entry per issued instruction and captures results from the CDB. It commits the head entry in program order: register writes go to regfile, store releases go to the LSB, and a misprediction generates a global flush. It produces the commit-side protocol whose consumer (regfile) clears its rename tag only when the committing tag matches.

---
 rtl/reorder_buffer.sv | 186 ++++++++++++++++++
 tb/tb_reorder_buffer.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retirement queue with CDB capture, operand forwarding and flush
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   rdy                    global enable; low freezes all state and registered outputs
//   issue_*                allocate one entry at tail (type 0 reg, 1 branch, 2 store, 3 ready reg)
//   rob_full, rob_alloc_tag  occupancy and the tag the next issue receives
//   cdb_*                  result broadcast captured into the matching busy entry
//   qN_tag -> qN_ready/qN_val  operand lookup with same-cycle CDB bypass
//   rob_to_reg_*           registered regfile commit strobe
//   rob_to_lsb_*           registered store release strobe
//   clr, clr_pc            registered flush pulse and fetch redirect
module reorder_buffer #(
    parameter int ROB_SIZE = 16,
    parameter int IDX_W    = 4,
    parameter int TAG_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             issue_valid,
    input  logic [1:0]       issue_type,
    input  logic [4:0]       issue_rd,
    input  logic [31:0]      issue_pc,
    input  logic             issue_pred_taken,
    input  logic [31:0]      issue_val,
    output logic             rob_full,
    output logic [TAG_W-1:0] rob_alloc_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_val,
    input  logic             cdb_taken,
    input  logic [31:0]      cdb_target,
    input  logic [TAG_W-1:0] q1_tag,
    input  logic [TAG_W-1:0] q2_tag,
    output logic             q1_ready,
    output logic             q2_ready,
    output logic [31:0]      q1_val,
    output logic [31:0]      q2_val,
    output logic             rob_to_reg_enable,
    output logic [4:0]       rob_to_reg_rd,
    output logic [TAG_W-1:0] rob_to_reg_rob_pos,
    output logic [31:0]      rob_to_reg_val,
    output logic             rob_to_lsb_commit,
    output logic [TAG_W-1:0] rob_to_lsb_tag,
    output logic             clr,
    output logic [31:0]      clr_pc
);

    localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(ROB_SIZE);
    localparam logic [1:0]     TYPE_BRANCH = 2'd1;
    localparam logic [1:0]     TYPE_STORE  = 2'd2;
    localparam logic [1:0]     TYPE_READY  = 2'd3;

    logic [ROB_SIZE-1:0] busy;
    logic [ROB_SIZE-1:0] ready;
    logic [ROB_SIZE-1:0] pred_taken_r;
    logic [ROB_SIZE-1:0] taken_r;
    logic [1:0]          type_r   [ROB_SIZE];
    logic [4:0]          rd_r     [ROB_SIZE];
    logic [31:0]         pc_r     [ROB_SIZE];
    logic [31:0]         val_r    [ROB_SIZE];
    logic [31:0]         target_r [ROB_SIZE];

    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic [IDX_W:0]   count;

    logic [IDX_W-1:0] cdb_idx;
    logic             cdb_wr;
    logic             issue_ok;
    logic             commit;
    logic             mispredict;

    // Tags are index+1 so that 0 can mean "no producer".
    function automatic logic [IDX_W-1:0] tag_idx(input logic [TAG_W-1:0] t);
        logic [TAG_W-1:0] m;
        m = t - TAG_W'(1);
        return m[IDX_W-1:0];
    endfunction

    // Returns {ready, value}: stored result first, then same-cycle CDB bypass.
    function automatic logic [32:0] query(input logic [TAG_W-1:0] t);
        logic [IDX_W-1:0] i;
        i = tag_idx(t);
        if (t == '0)
            return '0;
        if (busy[i] && ready[i])
            return {1'b1, val_r[i]};
        if (cdb_valid && cdb_tag == t)
            return {1'b1, cdb_val};
        return '0;
    endfunction

    assign rob_full      = (count == FULL_COUNT);
    assign rob_alloc_tag = {1'b0, tail} + TAG_W'(1);

    always_comb begin
        cdb_idx  = tag_idx(cdb_tag);
        cdb_wr   = cdb_valid && !clr && (cdb_tag != '0) && busy[cdb_idx];
        issue_ok = issue_valid && !rob_full && !clr;
        // A CDB write landing on the head this edge defers its commit by one edge.
        commit   = (count != '0) && busy[head] && ready[head] && !clr
                   && !(cdb_wr && cdb_idx == head);
        mispredict = commit && type_r[head] == TYPE_BRANCH
                     && taken_r[head] != pred_taken_r[head];
        {q1_ready, q1_val} = query(q1_tag);
        {q2_ready, q2_val} = query(q2_tag);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy               <= '0;
            ready              <= '0;
            head               <= '0;
            tail               <= '0;
            count              <= '0;
            rob_to_reg_enable  <= 1'b0;
            rob_to_reg_rd      <= '0;
            rob_to_reg_rob_pos <= '0;
            rob_to_reg_val     <= '0;
            rob_to_lsb_commit  <= 1'b0;
            rob_to_lsb_tag     <= '0;
            clr                <= 1'b0;
            clr_pc             <= '0;
        end else if (rdy) begin
            rob_to_reg_enable <= 1'b0;
            rob_to_lsb_commit <= 1'b0;
            clr               <= 1'b0;

            if (issue_ok) begin
                busy[tail]         <= 1'b1;
                ready[tail]        <= (issue_type == TYPE_READY);
                type_r[tail]       <= issue_type;
                rd_r[tail]         <= issue_rd;
                pc_r[tail]         <= issue_pc;
                pred_taken_r[tail] <= issue_pred_taken;
                val_r[tail]        <= issue_val;
                taken_r[tail]      <= 1'b0;
                target_r[tail]     <= '0;
                tail               <= tail + IDX_W'(1);
            end

            if (cdb_wr) begin
                val_r[cdb_idx]    <= cdb_val;
                taken_r[cdb_idx]  <= cdb_taken;
                target_r[cdb_idx] <= cdb_target;
                ready[cdb_idx]    <= 1'b1;
            end

            if (commit) begin
                busy[head]  <= 1'b0;
                ready[head] <= 1'b0;
                head        <= head + IDX_W'(1);
                if (type_r[head] != TYPE_STORE && rd_r[head] != 5'd0) begin
                    rob_to_reg_enable  <= 1'b1;
                    rob_to_reg_rd      <= rd_r[head];
                    rob_to_reg_rob_pos <= {1'b0, head} + TAG_W'(1);
                    rob_to_reg_val     <= val_r[head];
                end
                if (type_r[head] == TYPE_STORE) begin
                    rob_to_lsb_commit <= 1'b1;
                    rob_to_lsb_tag    <= {1'b0, head} + TAG_W'(1);
                end
            end

            case ({issue_ok, commit})
                2'b10:   count <= count + (IDX_W+1)'(1);
                2'b01:   count <= count - (IDX_W+1)'(1);
                default: ;
            endcase

            // Flush wins over any issue or CDB capture on the same edge.
            if (mispredict) begin
                busy   <= '0;
                ready  <= '0;
                head   <= '0;
                tail   <= '0;
                count  <= '0;
                clr    <= 1'b1;
                clr_pc <= taken_r[head] ? target_r[head] : pc_r[head] + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - self-checking bench for reorder_buffer with a queue-based reference model
module tb_reorder_buffer;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        issue_valid;
    logic [1:0]  issue_type;
    logic [4:0]  issue_rd;
    logic [31:0] issue_pc;
    logic        issue_pred_taken;
    logic [31:0] issue_val;
    logic        rob_full;
    logic [4:0]  rob_alloc_tag;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_val;
    logic        cdb_taken;
    logic [31:0] cdb_target;
    logic [4:0]  q1_tag;
    logic [4:0]  q2_tag;
    logic        q1_ready;
    logic        q2_ready;
    logic [31:0] q1_val;
    logic [31:0] q2_val;
    logic        rob_to_reg_enable;
    logic [4:0]  rob_to_reg_rd;
    logic [4:0]  rob_to_reg_rob_pos;
    logic [31:0] rob_to_reg_val;
    logic        rob_to_lsb_commit;
    logic [4:0]  rob_to_lsb_tag;
    logic        clr;
    logic [31:0] clr_pc;

    reorder_buffer dut (
        .clk                (clk),
        .rst                (rst),
        .rdy                (rdy),
        .issue_valid        (issue_valid),
        .issue_type         (issue_type),
        .issue_rd           (issue_rd),
        .issue_pc           (issue_pc),
        .issue_pred_taken   (issue_pred_taken),
        .issue_val          (issue_val),
        .rob_full           (rob_full),
        .rob_alloc_tag      (rob_alloc_tag),
        .cdb_valid          (cdb_valid),
        .cdb_tag            (cdb_tag),
        .cdb_val            (cdb_val),
        .cdb_taken          (cdb_taken),
        .cdb_target         (cdb_target),
        .q1_tag             (q1_tag),
        .q2_tag             (q2_tag),
        .q1_ready           (q1_ready),
        .q2_ready           (q2_ready),
        .q1_val             (q1_val),
        .q2_val             (q2_val),
        .rob_to_reg_enable  (rob_to_reg_enable),
        .rob_to_reg_rd      (rob_to_reg_rd),
        .rob_to_reg_rob_pos (rob_to_reg_rob_pos),
        .rob_to_reg_val     (rob_to_reg_val),
        .rob_to_lsb_commit  (rob_to_lsb_commit),
        .rob_to_lsb_tag     (rob_to_lsb_tag),
        .clr                (clr),
        .clr_pc             (clr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_pass;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference model: the ROB as a program-ordered list of in-flight instructions.
    typedef struct {
        logic [4:0]  tag;
        logic [1:0]  typ;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        pred;
        logic        done;
        logic [31:0] val;
        logic        taken;
        logic [31:0] target;
    } ent_t;

    ent_t        m_q[$];
    int          m_next_tag;
    logic        e_reg_en;
    logic [4:0]  e_reg_rd;
    logic [4:0]  e_reg_pos;
    logic [31:0] e_reg_val;
    logic        e_lsb;
    logic [4:0]  e_lsb_tag;
    logic        e_clr;
    logic [31:0] e_clr_pc;

    function automatic int m_find(input logic [4:0] t);
        for (int i = 0; i < m_q.size(); i++)
            if (m_q[i].tag == t)
                return i;
        return -1;
    endfunction

    task automatic m_query(input logic [4:0] t, output logic r, output logic [31:0] v);
        int i;
        i = m_find(t);
        r = 1'b0;
        v = 32'd0;
        if (t != 5'd0) begin
            if (i >= 0 && m_q[i].done) begin
                r = 1'b1;
                v = m_q[i].val;
            end else if (cdb_valid && cdb_tag == t) begin
                r = 1'b1;
                v = cdb_val;
            end
        end
    endtask

    task automatic m_reset();
        m_q.delete();
        m_next_tag = 1;
        e_reg_en = 0; e_reg_rd = 0; e_reg_pos = 0; e_reg_val = 0;
        e_lsb = 0; e_lsb_tag = 0; e_clr = 0; e_clr_pc = 0;
    endtask

    task automatic m_step();
        logic was_clr;
        int   hit;
        int   n0;
        bit   do_commit;
        bit   flush;
        ent_t h;
        ent_t e;
        if (rst) begin
            m_reset();
        end else if (rdy) begin
            was_clr  = e_clr;
            e_reg_en = 0;
            e_lsb    = 0;
            e_clr    = 0;
            if (!was_clr) begin
                hit   = (cdb_valid && cdb_tag != 5'd0) ? m_find(cdb_tag) : -1;
                n0    = m_q.size();
                flush = 0;
                do_commit = (n0 > 0) && m_q[0].done && (hit != 0);
                if (do_commit) begin
                    h = m_q[0];
                    if ((h.typ == 2'd0 || h.typ == 2'd1 || h.typ == 2'd3) && h.rd != 5'd0) begin
                        e_reg_en  = 1;
                        e_reg_rd  = h.rd;
                        e_reg_pos = h.tag;
                        e_reg_val = h.val;
                    end
                    if (h.typ == 2'd2) begin
                        e_lsb     = 1;
                        e_lsb_tag = h.tag;
                    end
                    if (h.typ == 2'd1 && h.taken != h.pred) begin
                        e_clr    = 1;
                        e_clr_pc = h.taken ? h.target : h.pc + 32'd4;
                        flush    = 1;
                    end
                end
                if (hit >= 0) begin
                    m_q[hit].val    = cdb_val;
                    m_q[hit].taken  = cdb_taken;
                    m_q[hit].target = cdb_target;
                    m_q[hit].done   = 1'b1;
                end
                if (do_commit)
                    void'(m_q.pop_front());
                if (flush) begin
                    m_q.delete();
                    m_next_tag = 1;
                end else if (issue_valid && n0 < 16) begin
                    e.tag    = 5'(m_next_tag);
                    e.typ    = issue_type;
                    e.rd     = issue_rd;
                    e.pc     = issue_pc;
                    e.pred   = issue_pred_taken;
                    e.done   = (issue_type == 2'd3);
                    e.val    = issue_val;
                    e.taken  = 1'b0;
                    e.target = 32'd0;
                    m_q.push_back(e);
                    m_next_tag = (m_next_tag == 16) ? 1 : m_next_tag + 1;
                end
            end
        end
    endtask

    // Compare everything against the model, advance the model, then take one edge.
    task automatic tick();
        logic        r;
        logic [31:0] v;
        #1;
        check("rob_full", 32'(rob_full), 32'(m_q.size() == 16));
        check("alloc_tag", 32'(rob_alloc_tag), 32'(m_next_tag));
        m_query(q1_tag, r, v);
        check("q1_ready", 32'(q1_ready), 32'(r));
        check("q1_val", q1_val, v);
        m_query(q2_tag, r, v);
        check("q2_ready", 32'(q2_ready), 32'(r));
        check("q2_val", q2_val, v);
        check("reg_enable", 32'(rob_to_reg_enable), 32'(e_reg_en));
        if (e_reg_en) begin
            check("reg_rd", 32'(rob_to_reg_rd), 32'(e_reg_rd));
            check("reg_pos", 32'(rob_to_reg_rob_pos), 32'(e_reg_pos));
            check("reg_val", rob_to_reg_val, e_reg_val);
        end
        check("lsb_commit", 32'(rob_to_lsb_commit), 32'(e_lsb));
        if (e_lsb)
            check("lsb_tag", 32'(rob_to_lsb_tag), 32'(e_lsb_tag));
        check("clr", 32'(clr), 32'(e_clr));
        if (e_clr)
            check("clr_pc", clr_pc, e_clr_pc);
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; rdy = 1;
        issue_valid = 0; issue_type = 0; issue_rd = 0; issue_pc = 0;
        issue_pred_taken = 0; issue_val = 0;
        cdb_valid = 0; cdb_tag = 0; cdb_val = 0; cdb_taken = 0; cdb_target = 0;
        q1_tag = 0; q2_tag = 0;
    endtask

    task automatic set_issue(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc,
                             input logic pred, input logic [31:0] val);
        issue_valid = 1; issue_type = t; issue_rd = rd; issue_pc = pc;
        issue_pred_taken = pred; issue_val = val;
    endtask

    task automatic set_cdb(input logic [4:0] t, input logic [31:0] val, input logic tk,
                           input logic [31:0] tgt);
        cdb_valid = 1; cdb_tag = t; cdb_val = val; cdb_taken = tk; cdb_target = tgt;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic rand_inputs();
        int i;
        rst              = ($urandom_range(0, 199) == 0);
        rdy              = ($urandom_range(0, 9) != 0);
        issue_valid      = ($urandom_range(0, 2) != 0);
        issue_type       = 2'($urandom_range(0, 3));
        issue_rd         = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        issue_pc         = $urandom & 32'hFFFF_FFFC;
        issue_pred_taken = 1'($urandom_range(0, 1));
        issue_val        = $urandom;
        cdb_valid        = ($urandom_range(0, 2) != 0);
        cdb_val          = $urandom;
        cdb_target       = $urandom & 32'hFFFF_FFFC;
        if (m_q.size() > 0 && $urandom_range(0, 3) != 0) begin
            i = $urandom_range(0, m_q.size() - 1);
            cdb_tag   = m_q[i].tag;
            cdb_taken = ($urandom_range(0, 7) == 0) ? !m_q[i].pred : m_q[i].pred;
        end else begin
            cdb_tag   = 5'($urandom_range(0, 16));
            cdb_taken = 1'($urandom_range(0, 1));
        end
        q1_tag = 5'($urandom_range(0, 16));
        if (m_q.size() > 0 && $urandom_range(0, 1) != 0)
            q2_tag = m_q[$urandom_range(0, m_q.size() - 1)].tag;
        else
            q2_tag = 5'($urandom_range(0, 16));
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        m_reset();
        check("rst_reg_enable", 32'(rob_to_reg_enable), 32'd0);
        check("rst_reg_rd", 32'(rob_to_reg_rd), 32'd0);
        check("rst_reg_pos", 32'(rob_to_reg_rob_pos), 32'd0);
        check("rst_reg_val", rob_to_reg_val, 32'd0);
        check("rst_lsb", 32'(rob_to_lsb_commit), 32'd0);
        check("rst_lsb_tag", 32'(rob_to_lsb_tag), 32'd0);
        check("rst_clr", 32'(clr), 32'd0);
        check("rst_clr_pc", clr_pc, 32'd0);
        check("rst_alloc_tag", 32'(rob_alloc_tag), 32'd1);
        check("rst_full", 32'(rob_full), 32'd0);
        rst = 0;

        // Type-3 entry commits one edge after issue.
        idle();
        set_issue(2'd3, 5'd5, 32'h0, 1'b0, 32'h11);
        tick();
        idle();
        check("t3_alloc_tag", 32'(rob_alloc_tag), 32'd2);
        tick();
        check("t3_reg_enable", 32'(rob_to_reg_enable), 32'd1);
        check("t3_reg_rd", 32'(rob_to_reg_rd), 32'd5);
        check("t3_reg_pos", 32'(rob_to_reg_rob_pos), 32'd1);
        check("t3_reg_val", rob_to_reg_val, 32'h11);

        // CDB bypass on the query path, commit the edge after the CDB write.
        do_reset();
        set_issue(2'd0, 5'd3, 32'h40, 1'b0, 32'h0);
        tick();
        idle();
        set_cdb(5'd1, 32'hABCD, 1'b0, 32'h0);
        q1_tag = 5'd1;
        #1;
        check("bypass_ready", 32'(q1_ready), 32'd1);
        check("bypass_val", q1_val, 32'hABCD);
        tick();
        idle();
        tick();
        check("bypass_commit_en", 32'(rob_to_reg_enable), 32'd1);
        check("bypass_commit_val", rob_to_reg_val, 32'hABCD);

        // Fill to capacity, overflow issue, then wrap.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            idle();
            set_issue(2'd0, 5'd1, 32'(i * 4), 1'b0, 32'h0);
            tick();
        end
        idle();
        check("full_after_16", 32'(rob_full), 32'd1);
        check("full_alloc_wrap", 32'(rob_alloc_tag), 32'd1);
        set_issue(2'd0, 5'd2, 32'h0, 1'b0, 32'h0);
        tick();
        idle();
        check("overflow_ignored", 32'(rob_alloc_tag), 32'd1);
        set_cdb(5'd1, 32'h55, 1'b0, 32'h0);
        tick();
        idle();
        set_issue(2'd0, 5'd2, 32'h0, 1'b0, 32'h0);
        tick();
        idle();
        check("full_commit_pos", 32'(rob_to_reg_rob_pos), 32'd1);
        set_issue(2'd0, 5'd2, 32'h0, 1'b0, 32'h0);
        tick();
        idle();
        check("wrap_full_again", 32'(rob_full), 32'd1);
        check("wrap_alloc_next", 32'(rob_alloc_tag), 32'd2);

        // Out-of-order completion retires in order.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle();
            set_issue(2'd0, 5'd7, 32'h0, 1'b0, 32'h0);
            tick();
        end
        for (int i = 3; i >= 1; i--) begin
            idle();
            set_cdb(5'(i), 32'(i * 16), 1'b0, 32'h0);
            tick();
        end
        idle();
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("order_en", 32'(rob_to_reg_enable), 32'd1);
            check("order_pos", 32'(rob_to_reg_rob_pos), 32'(i));
        end

        // Mispredicted branch flushes younger entries.
        do_reset();
        set_issue(2'd1, 5'd0, 32'h100, 1'b0, 32'h0);
        tick();
        idle();
        set_issue(2'd0, 5'd4, 32'h104, 1'b0, 32'h0);
        tick();
        idle();
        set_issue(2'd3, 5'd6, 32'h108, 1'b0, 32'h77);
        tick();
        idle();
        set_cdb(5'd1, 32'h0, 1'b1, 32'h200);
        tick();
        idle();
        tick();
        check("flush_clr", 32'(clr), 32'd1);
        check("flush_pc", clr_pc, 32'h200);
        check("flush_alloc", 32'(rob_alloc_tag), 32'd1);
        check("flush_full", 32'(rob_full), 32'd0);
        set_cdb(5'd2, 32'h99, 1'b0, 32'h0);
        set_issue(2'd3, 5'd9, 32'h300, 1'b0, 32'h5);
        tick();
        idle();
        q1_tag = 5'd2;
        #1;
        check("post_flush_clr", 32'(clr), 32'd0);
        check("post_flush_alloc", 32'(rob_alloc_tag), 32'd1);
        check("post_flush_q", 32'(q1_ready), 32'd0);

        // Store release held across a rdy stall.
        do_reset();
        set_issue(2'd2, 5'd0, 32'h400, 1'b0, 32'h0);
        tick();
        idle();
        set_cdb(5'd1, 32'h0, 1'b0, 32'h0);
        tick();
        idle();
        tick();
        check("store_commit", 32'(rob_to_lsb_commit), 32'd1);
        check("store_tag", 32'(rob_to_lsb_tag), 32'd1);
        rdy = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_commit", 32'(rob_to_lsb_commit), 32'd1);
            check("stall_tag", 32'(rob_to_lsb_tag), 32'd1);
        end
        rdy = 1;
        tick();
        check("store_deassert", 32'(rob_to_lsb_commit), 32'd0);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rand_inputs();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
